// File: rtl/alu_cmd_driver.sv
// Drives a 4-bit combinational ALU from a queued command stream and returns its settled outputs on a valid/ready port.
// Build macro ALU_CHECK_EN adds a golden-model compare and the sticky chk_err output.
module alu_cmd_driver #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_func,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_func,
    input  logic [3:0] alu_result,
    input  logic       alu_z,
    input  logic       alu_l,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_result,
    output logic       rsp_z,
    output logic       rsp_l,
    output logic [2:0] rsp_func,
    output logic       busy,
    output logic [7:0] done_cnt
`ifdef ALU_CHECK_EN
    ,
    output logic       chk_err
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    typedef struct packed {
        logic [2:0] func;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    state_t          state, state_next;
    cmd_t            mem [DEPTH];
    cmd_t            head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count, count_next;
    logic [CW-1:0]   settle_cnt;
    logic            push, pop, capture, rsp_hs;

    assign push    = cmd_valid && cmd_ready;
    assign pop     = (state == IDLE) && (count != '0);
    assign capture = (state == ISSUE) && (settle_cnt == LAST_CNT);
    assign rsp_hs  = (state == RESP) && rsp_valid && rsp_ready;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: defaults come first so no path through the block leaves a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (pop)     state_next = ISSUE;
            ISSUE:   if (capture) state_next = RESP;
            RESP:    if (rsp_hs)  state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + 1'b1;
        else if (pop && !push) count_next = count - 1'b1;
    end

    // cmd_ready is the registered complement of the full flag, so a full FIFO refuses even while popping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count     <= count_next;
            cmd_ready <= (count_next != FULL_CNT);
        end
    end

    // NOTE: the storage array has no reset; count guarantees stale entries are never popped.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{func: cmd_func, a: cmd_a, b: cmd_b};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_func   <= '0;
            settle_cnt <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_z      <= 1'b0;
            rsp_l      <= 1'b0;
            rsp_func   <= '0;
            busy       <= 1'b0;
            done_cnt   <= '0;
        end else begin
            busy <= (state_next != IDLE);
            if (pop) begin
                alu_a      <= head.a;
                alu_b      <= head.b;
                alu_func   <= head.func;
                settle_cnt <= '0;
            end else if (state == ISSUE) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            if (capture) begin
                rsp_result <= alu_result;
                rsp_z      <= alu_z;
                rsp_l      <= alu_l;
                rsp_func   <= alu_func;
                rsp_valid  <= 1'b1;
            end else if (rsp_hs) begin
                rsp_valid <= 1'b0;
                done_cnt  <= done_cnt + 1'b1;
            end
        end
    end

`ifdef ALU_CHECK_EN
    // Reference ALU: results wrap mod 16; LESS/EQ report only through L/Z with result 0
    function automatic logic [5:0] golden(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic       z, l;
        r = '0;
        z = 1'b0;
        l = 1'b0;
        case (f)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = ~a;
            3'd3:    r = a & b;
            3'd4:    r = a | b;
            3'd5:    r = a ^ b;
            3'd6:    l = (a < b);
            default: z = (a == b);
        endcase
        return {r, z, l};
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            chk_err <= 1'b0;
        else if (capture && ({alu_result, alu_z, alu_l} != golden(alu_func, alu_a, alu_b)))
            chk_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: table of single commands on a SETTLE=1 instance plus
// hand sequences for back-to-back, back-pressure, long settle and mid-operation reset.
module tb_alu_cmd_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       cmd_valid0, cmd_ready0, cmd_valid1, cmd_ready1;
    logic [2:0] cmd_func0, cmd_func1;
    logic [3:0] cmd_a0, cmd_b0, cmd_a1, cmd_b1;
    logic [3:0] alu_a0, alu_b0, alu_a1, alu_b1;
    logic [2:0] alu_func0, alu_func1;
    logic [3:0] alu_result0, alu_result1;
    logic       alu_z0, alu_l0, alu_z1, alu_l1;
    logic       rsp_valid0, rsp_ready0, rsp_valid1, rsp_ready1;
    logic [3:0] rsp_result0, rsp_result1;
    logic       rsp_z0, rsp_l0, rsp_z1, rsp_l1;
    logic [2:0] rsp_func0, rsp_func1;
    logic       busy0, busy1;
    logic [7:0] done_cnt0, done_cnt1;
    logic       alu_bad0;
`ifdef ALU_CHECK_EN
    logic       chk_err0, chk_err1;
`endif

    // External ALU stubs; alu_bad0 forces a wrong result on instance 0
    function automatic logic [5:0] stub_alu(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic       z, l;
        r = 4'h0;
        z = 1'b0;
        l = 1'b0;
        case (f)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = ~a;
            3'd3:    r = a & b;
            3'd4:    r = a | b;
            3'd5:    r = a ^ b;
            3'd6:    l = (a < b);
            default: z = (a == b);
        endcase
        return {r, z, l};
    endfunction

    always_comb begin
        {alu_result0, alu_z0, alu_l0} = stub_alu(alu_func0, alu_a0, alu_b0);
        if (alu_bad0) alu_result0 = 4'hF;
    end

    always_comb begin
        {alu_result1, alu_z1, alu_l1} = stub_alu(alu_func1, alu_a1, alu_b1);
    end

    alu_cmd_driver #(.DEPTH(4), .SETTLE(1)) dut0 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
        .cmd_func(cmd_func0), .cmd_a(cmd_a0), .cmd_b(cmd_b0),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_func(alu_func0),
        .alu_result(alu_result0), .alu_z(alu_z0), .alu_l(alu_l0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_result(rsp_result0), .rsp_z(rsp_z0), .rsp_l(rsp_l0), .rsp_func(rsp_func0),
        .busy(busy0), .done_cnt(done_cnt0)
`ifdef ALU_CHECK_EN
        , .chk_err(chk_err0)
`endif
    );

    alu_cmd_driver #(.DEPTH(4), .SETTLE(3)) dut1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_func(cmd_func1), .cmd_a(cmd_a1), .cmd_b(cmd_b1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_func(alu_func1),
        .alu_result(alu_result1), .alu_z(alu_z1), .alu_l(alu_l1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_result(rsp_result1), .rsp_z(rsp_z1), .rsp_l(rsp_l1), .rsp_func(rsp_func1),
        .busy(busy1), .done_cnt(done_cnt1)
`ifdef ALU_CHECK_EN
        , .chk_err(chk_err1)
`endif
    );

    typedef struct {
        logic [2:0] func;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] result;
        logic       z;
        logic       l;
    } vec_t;

    vec_t       vecs [12];
    vec_t       seq2 [3];
    logic [3:0] exp_q [$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp0(input string name, input int budget);
        int k;
        k = 0;
        while (!rsp_valid0 && k < budget) begin
            tick();
            k++;
        end
        n_checks++;
        if (!rsp_valid0) begin
            n_fail++;
            $display("FAIL %s: no response within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_rsp1(input string name, input int budget);
        int k;
        k = 0;
        while (!rsp_valid1 && k < budget) begin
            tick();
            k++;
        end
        n_checks++;
        if (!rsp_valid1) begin
            n_fail++;
            $display("FAIL %s: no response within %0d cycles", name, budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int seen;

        // func, a, b, result, z, l -- hand-computed for an ideal 4-bit ALU
        vecs[0]  = '{3'd0, 4'h7, 4'h9, 4'h0, 1'b0, 1'b0};
        vecs[1]  = '{3'd1, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0};
        vecs[2]  = '{3'd6, 4'h3, 4'h5, 4'h0, 1'b0, 1'b1};
        vecs[3]  = '{3'd7, 4'h9, 4'h9, 4'h0, 1'b1, 1'b0};
        vecs[4]  = '{3'd2, 4'h5, 4'h3, 4'hA, 1'b0, 1'b0};
        vecs[5]  = '{3'd3, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0};
        vecs[6]  = '{3'd4, 4'hC, 4'h3, 4'hF, 1'b0, 1'b0};
        vecs[7]  = '{3'd5, 4'hF, 4'h5, 4'hA, 1'b0, 1'b0};
        vecs[8]  = '{3'd6, 4'h5, 4'h3, 4'h0, 1'b0, 1'b0};
        vecs[9]  = '{3'd7, 4'h9, 4'h8, 4'h0, 1'b0, 1'b0};
        vecs[10] = '{3'd0, 4'h8, 4'h7, 4'hF, 1'b0, 1'b0};
        vecs[11] = '{3'd1, 4'h0, 4'h1, 4'hF, 1'b0, 1'b0};

        seq2[0]  = '{3'd1, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0};
        seq2[1]  = '{3'd6, 4'h3, 4'h5, 4'h0, 1'b0, 1'b1};
        seq2[2]  = '{3'd7, 4'h9, 4'h9, 4'h0, 1'b1, 1'b0};

        rst = 1'b1;
        cmd_valid0 = 1'b0; cmd_func0 = '0; cmd_a0 = '0; cmd_b0 = '0; rsp_ready0 = 1'b1;
        cmd_valid1 = 1'b0; cmd_func1 = '0; cmd_a1 = '0; cmd_b1 = '0; rsp_ready1 = 1'b1;
        alu_bad0 = 1'b0;
        tick();
        tick();
        check("reset cmd_ready", cmd_ready0, 1);
        check("reset rsp_valid", rsp_valid0, 0);
        check("reset busy", busy0, 0);
        check("reset done_cnt", done_cnt0, 0);
        check("reset alu_a", alu_a0, 0);
        check("reset alu_func", alu_func0, 0);
        check("reset rsp_result", rsp_result0, 0);
        check("reset cmd_ready settle3", cmd_ready1, 1);
        rst = 1'b0;

        // Single commands: push at E0, pop at E1, response after E2, handshake at E3
        for (int i = 0; i < 12; i++) begin
            cmd_valid0 = 1'b1;
            cmd_func0  = vecs[i].func;
            cmd_a0     = vecs[i].a;
            cmd_b0     = vecs[i].b;
            tick();
            cmd_valid0 = 1'b0;
            tick();
            check($sformatf("v%0d alu_a", i), alu_a0, vecs[i].a);
            check($sformatf("v%0d alu_b", i), alu_b0, vecs[i].b);
            check($sformatf("v%0d alu_func", i), alu_func0, vecs[i].func);
            check($sformatf("v%0d busy", i), busy0, 1);
            check($sformatf("v%0d early rsp_valid", i), rsp_valid0, 0);
            tick();
            check($sformatf("v%0d rsp_valid", i), rsp_valid0, 1);
            check($sformatf("v%0d rsp_result", i), rsp_result0, vecs[i].result);
            check($sformatf("v%0d rsp_z", i), rsp_z0, vecs[i].z);
            check($sformatf("v%0d rsp_l", i), rsp_l0, vecs[i].l);
            check($sformatf("v%0d rsp_func", i), rsp_func0, vecs[i].func);
            tick();
            check($sformatf("v%0d rsp_valid drop", i), rsp_valid0, 0);
            check($sformatf("v%0d done_cnt", i), done_cnt0, i + 1);
            check($sformatf("v%0d busy idle", i), busy0, 0);
        end

        // Back-to-back pushes come out in order
        for (int i = 0; i < 3; i++) begin
            cmd_valid0 = 1'b1;
            cmd_func0  = seq2[i].func;
            cmd_a0     = seq2[i].a;
            cmd_b0     = seq2[i].b;
            tick();
        end
        cmd_valid0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_rsp0($sformatf("b2b wait %0d", k), 10);
            check($sformatf("b2b%0d result", k), rsp_result0, seq2[k].result);
            check($sformatf("b2b%0d z", k), rsp_z0, seq2[k].z);
            check($sformatf("b2b%0d l", k), rsp_l0, seq2[k].l);
            check($sformatf("b2b%0d func", k), rsp_func0, seq2[k].func);
            tick();
        end
        check("b2b done_cnt", done_cnt0, 15);

        // Back-pressure: 1 in flight + 4 queued, the sixth offer is refused
        rsp_ready0 = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            cmd_valid0 = 1'b1;
            cmd_func0  = 3'd0;
            cmd_a0     = 4'(i);
            cmd_b0     = 4'h1;
            if (cmd_ready0) begin
                exp_q.push_back(4'(i + 1));
                acc++;
            end
            tick();
        end
        cmd_valid0 = 1'b0;
        check("full accepted", acc, 5);
        check("full cmd_ready", cmd_ready0, 0);
        repeat (4) tick();
        check("full cmd_ready held", cmd_ready0, 0);
        check("full rsp_valid held", rsp_valid0, 1);
        check("full done_cnt held", done_cnt0, 15);
        rsp_ready0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_rsp0($sformatf("drain wait %0d", k), 10);
            check($sformatf("drain%0d result", k), rsp_result0, (exp_q.size() > 0) ? exp_q.pop_front() : 4'h0);
            tick();
            if (k == 0) begin
                tick();
                check("cmd_ready after pop", cmd_ready0, 1);
            end
        end
        check("drain done_cnt", done_cnt0, 20);
        check("drain cmd_ready", cmd_ready0, 1);

        // SETTLE=3: operands held three cycles, response four edges after the push
        cmd_valid1 = 1'b1;
        cmd_func1  = 3'd2;
        cmd_a1     = 4'h5;
        cmd_b1     = 4'h0;
        tick();
        cmd_valid1 = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check($sformatf("settle c%0d alu_a", c), alu_a1, 5);
            check($sformatf("settle c%0d alu_func", c), alu_func1, 2);
            check($sformatf("settle c%0d rsp_valid", c), rsp_valid1, 0);
        end
        tick();
        check("settle rsp_valid", rsp_valid1, 1);
        check("settle rsp_result", rsp_result1, 4'hA);
        check("settle rsp_func", rsp_func1, 2);
        tick();
        check("settle done_cnt", done_cnt1, 1);

        // Reset during ISSUE with two commands queued
        cmd_valid1 = 1'b1;
        cmd_func1 = 3'd0; cmd_a1 = 4'h1; cmd_b1 = 4'h2; tick();
        cmd_func1 = 3'd1; cmd_a1 = 4'h4; cmd_b1 = 4'h1; tick();
        cmd_func1 = 3'd4; cmd_a1 = 4'h1; cmd_b1 = 4'h2; tick();
        cmd_valid1 = 1'b0;
        check("pre-reset busy", busy1, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid-reset busy", busy1, 0);
        check("mid-reset rsp_valid", rsp_valid1, 0);
        check("mid-reset cmd_ready", cmd_ready1, 1);
        check("mid-reset done_cnt", done_cnt1, 0);
        check("mid-reset done_cnt other", done_cnt0, 0);
        seen = 0;
        repeat (12) begin
            tick();
            if (rsp_valid1 || busy1) seen++;
        end
        check("no stale activity", seen, 0);
        cmd_valid1 = 1'b1;
        cmd_func1 = 3'd7; cmd_a1 = 4'h4; cmd_b1 = 4'h4;
        tick();
        cmd_valid1 = 1'b0;
        wait_rsp1("post-reset wait", 10);
        check("post-reset result", rsp_result1, 0);
        check("post-reset z", rsp_z1, 1);
        check("post-reset func", rsp_func1, 7);
        tick();
        check("post-reset done_cnt", done_cnt1, 1);

`ifdef ALU_CHECK_EN
        check("chk_err clean", chk_err0, 0);
        alu_bad0 = 1'b1;
        cmd_valid0 = 1'b1;
        cmd_func0 = 3'd0; cmd_a0 = 4'h1; cmd_b0 = 4'h1;
        tick();
        cmd_valid0 = 1'b0;
        tick();
        tick();
        check("bad rsp_result", rsp_result0, 4'hF);
        check("chk_err set", chk_err0, 1);
        alu_bad0 = 1'b0;
        repeat (6) tick();
        check("chk_err sticky", chk_err0, 1);
        check("chk_err other clean", chk_err1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("chk_err cleared", chk_err0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
